// File: rtl/core_types_pkg.sv
// Shared ITLB types: megapage array geometry, the array entry layout,
// SFENCE.VMA scope encoding and the fill-controller state encoding.
package core_types_pkg;

    localparam int ITLB_4MBPAGE_INDEX_WIDTH = 2;
    localparam int ITLB_4MBPAGE_NUM_WAYS    = 2;
    localparam int ITLB_4MBPAGE_NUM_SETS    = 1 << ITLB_4MBPAGE_INDEX_WIDTH;

    // Position of the G bit inside the {D,A,G,U,X,W,R,V} permission byte
    localparam int PTE_G_BIT = 5;

    typedef struct packed {
        logic [8:0]  asid;
        logic [9:0]  vpn1;
        logic [11:0] ppn1;
        logic [7:0]  perm;
    } itlb_4MB_entry_t;

    typedef enum logic [1:0] {
        SFENCE_ALL      = 2'd0,
        SFENCE_ASID     = 2'd1,
        SFENCE_VPN      = 2'd2,
        SFENCE_VPN_ASID = 2'd3
    } sfence_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL_WR = 2'd1,
        ST_FLUSH   = 2'd2
    } itlb_fill_state_t;

endpackage

// File: rtl/itlb_4MB_victim_sel.sv
// Two-way victim choice: duplicate entry first, then lowest invalid way,
// otherwise the way named by the set's LRU bit.
module itlb_4MB_victim_sel (
    input  logic [1:0] valid,
    input  logic [1:0] dup_hit,
    input  logic       lru,
    output logic       way
);

    always_comb begin
        way = lru;
        if (dup_hit[0])     way = 1'b0;
        else if (dup_hit[1]) way = 1'b1;
        else if (!valid[0])  way = 1'b0;
        else if (!valid[1])  way = 1'b1;
    end

endmodule

// File: rtl/itlb_4mb_fill_ctrl.sv
// Write/maintenance side of the ITLB megapage array: PTW fills, victim
// choice, per-entry valid bits, per-set LRU and SFENCE.VMA sweeps.
module itlb_4mb_fill_ctrl
    import core_types_pkg::*;
#(
    parameter int ASID_WIDTH = 9,
    parameter int VPN1_WIDTH = 10,
    parameter int PPN1_WIDTH = 12,
    parameter int NUM_WAYS   = ITLB_4MBPAGE_NUM_WAYS
) (
    input  logic                                          CLK,
    input  logic                                          nRST,
    input  logic                                          fill_valid,
    output logic                                          fill_ready,
    input  logic [VPN1_WIDTH-1:0]                         fill_VPN1,
    input  logic [ASID_WIDTH-1:0]                         fill_ASID,
    input  logic [PPN1_WIDTH-1:0]                         fill_PPN1,
    input  logic [7:0]                                    fill_perm,
    input  logic                                          sfence_valid,
    output logic                                          sfence_ready,
    input  logic [1:0]                                    sfence_mode,
    input  logic [VPN1_WIDTH-1:0]                         sfence_VPN1,
    input  logic [ASID_WIDTH-1:0]                         sfence_ASID,
    output logic                                          sfence_done,
    input  logic                                          hit_valid,
    input  logic [ITLB_4MBPAGE_INDEX_WIDTH-1:0]           hit_index,
    input  logic                                          hit_way,
    output logic                                          wr_valid,
    output logic [ITLB_4MBPAGE_INDEX_WIDTH-1:0]           wr_index,
    output logic                                          wr_way,
    output logic [ASID_WIDTH+VPN1_WIDTH+PPN1_WIDTH+8-1:0] wr_entry,
    output logic [ITLB_4MBPAGE_NUM_SETS*NUM_WAYS-1:0]     valid_vec
);

    localparam int IW       = ITLB_4MBPAGE_INDEX_WIDTH;
    localparam int NUM_SETS = ITLB_4MBPAGE_NUM_SETS;

    itlb_fill_state_t      state_reg;
    logic [VPN1_WIDTH-1:0] fill_vpn_reg;
    logic [ASID_WIDTH-1:0] fill_asid_reg;
    logic [PPN1_WIDTH-1:0] fill_ppn_reg;
    logic [7:0]            fill_perm_reg;
    sfence_mode_t          mode_reg;
    logic [VPN1_WIDTH-1:0] fl_vpn_reg;
    logic [ASID_WIDTH-1:0] fl_asid_reg;
    logic [IW-1:0]         ptr_reg;
    logic                  done_reg;
    logic [NUM_SETS-1:0]   lru_reg;
    logic [NUM_WAYS-1:0]   valid_reg  [NUM_SETS];
    logic [NUM_WAYS-1:0]   sh_g_reg   [NUM_SETS];
    logic [VPN1_WIDTH-1:0] sh_vpn_reg [NUM_SETS][NUM_WAYS];
    logic [ASID_WIDTH-1:0] sh_asid_reg[NUM_SETS][NUM_WAYS];

    logic [IW-1:0]       fill_idx;
    logic [IW-1:0]       sfence_idx;
    logic [NUM_WAYS-1:0] dup_hit;
    logic [NUM_WAYS-1:0] flush_hit;
    logic                flush_last;
    logic                fill_g;

    // Same XOR-fold hash as the lookup side so both agree on the set
    assign fill_idx   = fill_vpn_reg[IW-1:0] ^ fill_vpn_reg[2*IW-1:IW];
    assign sfence_idx = sfence_VPN1[IW-1:0] ^ sfence_VPN1[2*IW-1:IW];
    assign fill_g     = fill_perm_reg[PTE_G_BIT];
    assign flush_last = (mode_reg == SFENCE_VPN) || (mode_reg == SFENCE_VPN_ASID) ||
                        (ptr_reg == IW'(NUM_SETS - 1));

    assign sfence_ready = (state_reg == ST_IDLE);
    assign fill_ready   = (state_reg == ST_IDLE) && !sfence_valid;
    assign sfence_done  = done_reg;
    assign wr_valid     = (state_reg == ST_FILL_WR);
    assign wr_index     = fill_idx;
    assign wr_entry     = {fill_asid_reg, fill_vpn_reg, fill_ppn_reg, fill_perm_reg};

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        logic fl_vpn_eq, fl_asid_eq, fl_glob;
        assign dup_hit[gi] = valid_reg[fill_idx][gi] &&
                             (sh_vpn_reg[fill_idx][gi] == fill_vpn_reg) &&
                             ((sh_asid_reg[fill_idx][gi] == fill_asid_reg) ||
                              sh_g_reg[fill_idx][gi] || fill_g);
        assign fl_vpn_eq   = (sh_vpn_reg[ptr_reg][gi] == fl_vpn_reg);
        assign fl_asid_eq  = (sh_asid_reg[ptr_reg][gi] == fl_asid_reg);
        assign fl_glob     = sh_g_reg[ptr_reg][gi];
        assign flush_hit[gi] = (mode_reg == SFENCE_ALL) ||
                               ((mode_reg == SFENCE_ASID) && fl_asid_eq && !fl_glob) ||
                               ((mode_reg == SFENCE_VPN) && fl_vpn_eq) ||
                               ((mode_reg == SFENCE_VPN_ASID) && fl_vpn_eq && fl_asid_eq && !fl_glob);
    end

    for (genvar gs = 0; gs < NUM_SETS; gs++) begin : g_set
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_bit
            assign valid_vec[gs*NUM_WAYS+gi] = valid_reg[gs][gi];
        end
    end

    itlb_4MB_victim_sel u_victim_sel (
        .valid   (valid_reg[fill_idx]),
        .dup_hit (dup_hit),
        .lru     (lru_reg[fill_idx]),
        .way     (wr_way)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= ST_IDLE;
            fill_vpn_reg  <= '0;
            fill_asid_reg <= '0;
            fill_ppn_reg  <= '0;
            fill_perm_reg <= '0;
            mode_reg      <= SFENCE_ALL;
            fl_vpn_reg    <= '0;
            fl_asid_reg   <= '0;
            ptr_reg       <= '0;
            done_reg      <= 1'b0;
            lru_reg       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                sh_g_reg[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    sh_vpn_reg[s][w]  <= '0;
                    sh_asid_reg[s][w] <= '0;
                end
            end
        end else begin
            done_reg <= 1'b0;
            // The fill's LRU write below comes later, so it wins on a same-set clash
            if (hit_valid) lru_reg[hit_index] <= ~hit_way;
            case (state_reg)
                ST_IDLE: begin
                    if (sfence_valid) begin
                        mode_reg    <= sfence_mode_t'(sfence_mode);
                        fl_vpn_reg  <= sfence_VPN1;
                        fl_asid_reg <= sfence_ASID;
                        ptr_reg     <= sfence_mode[1] ? sfence_idx : '0;
                        state_reg   <= ST_FLUSH;
                    end else if (fill_valid) begin
                        fill_vpn_reg  <= fill_VPN1;
                        fill_asid_reg <= fill_ASID;
                        fill_ppn_reg  <= fill_PPN1;
                        fill_perm_reg <= fill_perm;
                        state_reg     <= ST_FILL_WR;
                    end
                end
                ST_FILL_WR: begin
                    valid_reg[fill_idx][wr_way]   <= 1'b1;
                    sh_vpn_reg[fill_idx][wr_way]  <= fill_vpn_reg;
                    sh_asid_reg[fill_idx][wr_way] <= fill_asid_reg;
                    sh_g_reg[fill_idx][wr_way]    <= fill_g;
                    lru_reg[fill_idx]             <= ~wr_way;
                    state_reg                     <= ST_IDLE;
                end
                ST_FLUSH: begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (flush_hit[w]) valid_reg[ptr_reg][w] <= 1'b0;
                    end
                    if (flush_last) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_itlb_4mb_fill_ctrl.sv
// Bench for the ITLB megapage fill controller: expected array writes are
// queued as fills are driven and compared when wr_valid appears.
module tb_itlb_4mb_fill_ctrl;
    import core_types_pkg::*;

    localparam int IW = ITLB_4MBPAGE_INDEX_WIDTH;
    localparam int NS = ITLB_4MBPAGE_NUM_SETS;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          fill_valid, fill_ready;
    logic [9:0]    fill_VPN1;
    logic [8:0]    fill_ASID;
    logic [11:0]   fill_PPN1;
    logic [7:0]    fill_perm;
    logic          sfence_valid, sfence_ready, sfence_done;
    logic [1:0]    sfence_mode;
    logic [9:0]    sfence_VPN1;
    logic [8:0]    sfence_ASID;
    logic          hit_valid;
    logic [IW-1:0] hit_index;
    logic          hit_way;
    logic          wr_valid;
    logic [IW-1:0] wr_index;
    logic          wr_way;
    logic [38:0]   wr_entry;
    logic [NS*2-1:0] valid_vec;

    itlb_4mb_fill_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_VPN1(fill_VPN1),
        .fill_ASID(fill_ASID), .fill_PPN1(fill_PPN1), .fill_perm(fill_perm),
        .sfence_valid(sfence_valid), .sfence_ready(sfence_ready), .sfence_mode(sfence_mode),
        .sfence_VPN1(sfence_VPN1), .sfence_ASID(sfence_ASID), .sfence_done(sfence_done),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_way(wr_way), .wr_entry(wr_entry),
        .valid_vec(valid_vec)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          way;
        logic [38:0]   entry;
    } wr_exp_t;

    wr_exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int done_pulses = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h @%0t", tag, got, $time);
        end
    endtask

    function automatic logic [38:0] pack_entry(input logic [9:0] vpn, input logic [8:0] asid,
                                               input logic [11:0] ppn, input logic [7:0] perm);
        itlb_4MB_entry_t e;
        e.asid = asid;
        e.vpn1 = vpn;
        e.ppn1 = ppn;
        e.perm = perm;
        return e;
    endfunction

    // Scoreboard side: every write strobe must match the oldest expectation
    always @(negedge CLK) begin
        if (nRST && wr_valid) begin
            if (sb_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                wr_exp_t e;
                e = sb_q.pop_front();
                check("wr_index", wr_index, e.idx);
                check("wr_way", wr_way, e.way);
                check("wr_entry", wr_entry, e.entry);
            end
        end
        if (sfence_done) done_pulses++;
    end

    task automatic push_exp(input logic [9:0] vpn, input logic [8:0] asid, input logic [11:0] ppn,
                            input logic [7:0] perm, input logic [IW-1:0] idx, input logic way);
        wr_exp_t e;
        e.idx   = idx;
        e.way   = way;
        e.entry = pack_entry(vpn, asid, ppn, perm);
        sb_q.push_back(e);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again
    task automatic do_fill(input logic [9:0] vpn, input logic [8:0] asid, input logic [11:0] ppn,
                           input logic [7:0] perm, input logic [IW-1:0] exp_idx, input logic exp_way,
                           input logic with_hit, input logic [IW-1:0] h_idx, input logic h_way);
        fill_VPN1 = vpn; fill_ASID = asid; fill_PPN1 = ppn; fill_perm = perm;
        fill_valid = 1'b1;
        push_exp(vpn, asid, ppn, perm, exp_idx, exp_way);
        @(negedge CLK);
        check("fill_ready", fill_ready, 1);
        @(posedge CLK); #1;
        fill_valid = 1'b0;
        if (with_hit) begin
            hit_valid = 1'b1; hit_index = h_idx; hit_way = h_way;
        end
        @(posedge CLK); #1;
        hit_valid = 1'b0;
    endtask

    task automatic do_sfence(input logic [1:0] mode, input logic [9:0] vpn, input logic [8:0] asid,
                             input int exp_cycles);
        int  cycles;
        logic fr_seen, got_done;
        sfence_mode = mode; sfence_VPN1 = vpn; sfence_ASID = asid;
        sfence_valid = 1'b1;
        @(negedge CLK);
        check("sfence_ready", sfence_ready, 1);
        check("fill_ready_vs_sfence", fill_ready, 0);
        @(posedge CLK); #1;
        sfence_valid = 1'b0;
        cycles = 0; fr_seen = 1'b0; got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge CLK);
            if (sfence_done) got_done = 1'b1;
            else begin
                cycles++;
                if (fill_ready) fr_seen = 1'b1;
            end
        end
        check("sfence_done_seen", got_done, 1);
        check("flush_cycles", cycles, exp_cycles);
        check("fill_ready_in_flush", fr_seen, 0);
        @(negedge CLK);
        check("sfence_done_one_cycle", sfence_done, 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int saved_done;
        nRST = 1'b0;
        fill_valid = 1'b0; fill_VPN1 = '0; fill_ASID = '0; fill_PPN1 = '0; fill_perm = '0;
        sfence_valid = 1'b0; sfence_mode = '0; sfence_VPN1 = '0; sfence_ASID = '0;
        hit_valid = 1'b0; hit_index = '0; hit_way = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_valid_vec", valid_vec, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_sfence_done", sfence_done, 0);
        check("rst_sfence_ready", sfence_ready, 1);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Set 0 fills walk through invalid-way, LRU and duplicate cases
        do_fill(10'h3A5, 9'h01, 12'h111, 8'h01, 0, 0, 0, 0, 0);
        check("vv_after_A", valid_vec, 8'h01);
        do_fill(10'h006, 9'h01, 12'h222, 8'h01, 3, 0, 0, 0, 0);
        check("vv_after_B", valid_vec, 8'h41);
        do_fill(10'h3A5, 9'h02, 12'h333, 8'h01, 0, 1, 0, 0, 0);
        check("vv_after_C", valid_vec, 8'h43);
        do_fill(10'h3A5, 9'h03, 12'h444, 8'h01, 0, 0, 0, 0, 0);
        do_fill(10'h3A5, 9'h02, 12'h555, 8'h01, 0, 1, 0, 0, 0);
        check("vv_after_dup", valid_vec, 8'h43);

        // Hit to way 0 during a way-1 fill of the same set: fill's LRU update wins
        do_fill(10'h3A5, 9'h02, 12'h666, 8'h01, 0, 1, 1, 0, 0);
        do_fill(10'h3A5, 9'h04, 12'h777, 8'h01, 0, 0, 0, 0, 0);
        hit_valid = 1'b1; hit_index = 0; hit_way = 1'b1;
        @(posedge CLK); #1;
        hit_valid = 1'b0;
        do_fill(10'h3A5, 9'h05, 12'h888, 8'h01, 0, 0, 0, 0, 0);

        do_fill(10'h003, 9'h01, 12'h999, 8'h21, 3, 1, 0, 0, 0);
        do_fill(10'h001, 9'h01, 12'h123, 8'h01, 1, 0, 0, 0, 0);
        check("vv_before_asid_flush", valid_vec, 8'hC7);

        do_sfence(2'd1, 10'h000, 9'h01, 4);
        check("vv_after_asid_flush", valid_vec, 8'h83);

        do_fill(10'h006, 9'h01, 12'h246, 8'h01, 3, 0, 0, 0, 0);
        check("vv_before_vpn_flush", valid_vec, 8'hC3);

        // Simultaneous sfence and fill: sfence first, fill right after done
        fill_VPN1 = 10'h006; fill_ASID = 9'h03; fill_PPN1 = 12'hABC; fill_perm = 8'h01;
        fill_valid = 1'b1;
        sfence_mode = 2'd2; sfence_VPN1 = 10'h006; sfence_ASID = 9'h000;
        sfence_valid = 1'b1;
        @(negedge CLK);
        check("both_sfence_ready", sfence_ready, 1);
        check("both_fill_ready", fill_ready, 0);
        @(posedge CLK); #1;
        sfence_valid = 1'b0;
        @(negedge CLK);
        check("vpn_flush_fill_ready", fill_ready, 0);
        check("vpn_flush_done_early", sfence_done, 0);
        @(negedge CLK);
        check("vpn_flush_done", sfence_done, 1);
        check("vpn_flush_fill_ready_after", fill_ready, 1);
        check("vv_after_vpn_flush", valid_vec, 8'h83);
        push_exp(10'h006, 9'h03, 12'hABC, 8'h01, 3, 0);
        @(posedge CLK); #1;
        fill_valid = 1'b0;
        @(posedge CLK); #1;
        check("vv_after_held_fill", valid_vec, 8'hC3);

        do_sfence(2'd3, 10'h006, 9'h03, 1);
        check("vv_after_vpn_asid_flush", valid_vec, 8'h83);
        check("done_pulses", done_pulses, 3);

        // Reset in the middle of a full sweep drops it without a done pulse
        saved_done = done_pulses;
        sfence_mode = 2'd0; sfence_valid = 1'b1;
        @(posedge CLK); #1;
        sfence_valid = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        check("midflush_rst_valid_vec", valid_vec, 0);
        check("midflush_rst_idle", sfence_ready, 1);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (6) @(negedge CLK);
        check("midflush_no_done", done_pulses, saved_done);
        check("midflush_valid_vec", valid_vec, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/itlb_4mb_fill_ctrl.md
Name: itlb_4MB_fill_ctrl

Overview:
Writer/maintenance side of the ITLB 4MB (Sv32 megapage) array. Accepts megapage fills from the page table walker and chooses a set and victim way. Drives the array write port and owns the per-entry valid bits and per-set LRU state. Also executes SFENCE.VMA invalidations, using the same set-index hash the lookup side uses so that writes and lookups always agree on the set.

Parameters:
ASID_WIDTH, 9, address-space ID width
VPN1_WIDTH, 10, megapage VPN (VPN[19:10]) width
PPN1_WIDTH, 12, megapage PPN (PPN[21:10]) width
NUM_WAYS, 2, associativity (fixed 2; one LRU bit per set)

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
fill_valid  in  1  PTW megapage fill offered
fill_ready  out  1  fill accepted this cycle when high with fill_valid
fill_VPN1  in  VPN1_WIDTH  fill tag
fill_ASID  in  ASID_WIDTH  fill ASID
fill_PPN1  in  PPN1_WIDTH  fill PPN
fill_perm  in  8  PTE bits {D,A,G,U,X,W,R,V}
sfence_valid  in  1  invalidate request
sfence_ready  out  1  invalidate accepted
sfence_mode  in  2  0 all, 1 by ASID, 2 by VPN, 3 by VPN+ASID
sfence_VPN1  in  VPN1_WIDTH  invalidate VPN
sfence_ASID  in  ASID_WIDTH  invalidate ASID
sfence_done  out  1  one-cycle pulse when the invalidate completes
hit_valid  in  1  lookup hit, LRU update
hit_index  in  ITLB_4MBPAGE_INDEX_WIDTH  hit set
hit_way  in  1  hit way
wr_valid  out  1  array write strobe
wr_index  out  ITLB_4MBPAGE_INDEX_WIDTH  write set
wr_way  out  1  write way
wr_entry  out  ASID_WIDTH+VPN1_WIDTH+PPN1_WIDTH+8  {ASID,VPN1,PPN1,perm}
valid_vec  out  NUM_SETS*NUM_WAYS  per-entry valid to lookup side, bit = set*NUM_WAYS+way

Behaviour:
- Clock and reset: single clock CLK. Reset nRST is asynchronous and active-low.
- Reset state: state IDLE; all valid bits 0; all LRU bits 0; shadow tags 0. Outputs wr_valid=0, sfence_done=0, valid_vec=0.
- NUM_SETS = 2^ITLB_4MBPAGE_INDEX_WIDTH.
- Set index: idx(v) = v[IW-1:0] ^ v[2IW-1:IW], with IW = ITLB_4MBPAGE_INDEX_WIDTH.
- Shadow storage: internal copy of {VPN1, ASID, G} per entry, used for duplicate detection and invalidate matching.
- Readies are combinational:
  - sfence_ready = (state==IDLE).
  - fill_ready = (state==IDLE) && !sfence_valid. Sfence has priority over fill.
- FSM states: IDLE, FILL_WR, FLUSH.
- IDLE:
  - On sfence accept, latch mode/VPN1/ASID and go to FLUSH. The sweep pointer starts at 0 for modes 0/1, or at idx(sfence_VPN1) for modes 2/3.
  - Otherwise, on fill accept, latch the fill and go to FILL_WR.
- FILL_WR (exactly one cycle, so write latency is 1 cycle after accept):
  - wr_valid=1, wr_index=idx(VPN1).
  - Way selection, first match wins:
    1. A valid way with the same VPN1 and (same ASID, or G set in either entry) is overwritten.
    2. Else the lowest-numbered invalid way.
    3. Else the way given by the LRU bit.
  - Set valid and update the shadow for the written way. LRU points to the other way. Return to IDLE.
- FLUSH (one set per cycle). Clear valid on entries matching the mode:
  - Mode 0: all entries.
  - Mode 1: ASID match && !G.
  - Mode 2: VPN1 match (global included).
  - Mode 3: VPN1 match && ASID match && !G.
  - Modes 2/3 visit only the hashed set, 1 cycle.
  - Modes 0/1 visit sets 0..NUM_SETS-1 in order.
  - After the last set, pulse sfence_done=1 for one cycle (the cycle state returns to IDLE). LRU bits are untouched.
- LRU update: hit_valid sets LRU[hit_index] = ~hit_way in any state. If a hit and a FILL_WR target the same set in the same cycle, the fill's update wins.
- No fill is accepted during FLUSH, so no stale fill can land after an invalidate begins.
- Reset mid-FILL_WR or mid-FLUSH returns to IDLE with all entries invalid. The pending request is dropped; no done pulse is generated.

Decomposition:
- Package core_types_pkg: ITLB_4MBPAGE_INDEX_WIDTH (existing; 2 for this release), ITLB_4MBPAGE_NUM_WAYS, struct itlb_4MB_entry_t {ASID, VPN1, PPN1, perm}, enum sfence_mode_t.
- Sub-module itlb_4MB_victim_sel: combinational way choice from {valid[1:0], dup_hit[1:0], lru}.

Test Plan:
- Reset, then fill VPN1=0x3A5 ASID=0x01 -> one cycle later wr_valid=1, wr_index=0, wr_way=0; valid_vec[0]=1.
- Second fill VPN1=0x006 ASID=0x01 -> wr_index=3, wr_way=0. Then VPN1=0x3A5 ASID=0x02 -> set 0, way 1. Third same-set fill with no hits -> way 0 (LRU), so the entry for ASID 0x01 is evicted.
- Refill VPN1=0x3A5 ASID=0x02 with new PPN1 -> overwrites set 0 way 1 (duplicate); no extra valid bit set.
- hit_valid idx 0 way 0 in the same cycle as a fill to set 0 way 1 -> LRU[0]=0 afterwards (fill wins).
- sfence mode 1 ASID=0x01, with a G=1 entry under ASID 0x01 in set 3 -> 4-cycle sweep; non-global ASID-0x01 entries cleared, global entry kept; sfence_done pulses once; fill_ready low throughout.
- sfence_valid and fill_valid together in IDLE -> sfence accepted, fill_ready=0. Mode 2 VPN1=0x006 -> 1-cycle flush of set 3 only. Then the fill is accepted.
